// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares a single slow-memory port between the I-cache and D-cache.
//   Each cache holds read/write + addr (+ wdata) until it sees a one-cycle
//   ready pulse. The arbiter picks one requester, registers its command onto
//   the memory port, holds it until mem_ready, and routes the ready pulse back
//   to that requester only.
//
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests go to the cache that was NOT granted
//                 last; last_grant is updated on every grant.
//     undefined : fixed priority, D-cache over I-cache.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata   I-cache request
//   i_rdata, i_ready                I-cache response
//   d_read/d_write/d_addr/d_wdata   D-cache request
//   d_rdata, d_ready                D-cache response
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory command
//   mem_rdata, mem_ready            memory response
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no grant; arbitrate and latch the winner's command
// GNT_I   | I-cache command on the memory port, waiting for mem_ready
// GNT_D   | D-cache command on the memory port, waiting for mem_ready
// DONE    | one quiet cycle so the served cache can drop its request
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic req_i;
  logic req_d;
  logic pick_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = D-cache was granted most recently, 0 = I-cache.
  logic last_grant_q, last_grant_d;

  // A lone requester always wins; on a tie the one not served last wins.
  assign pick_d = req_d & (~req_i | ~last_grant_q);
`else
  assign pick_d = req_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_i | req_d) begin
          if (pick_d) begin
            state_d     = ST_GNT_D;
            // A simultaneous write request takes precedence over the read.
            mem_read_d  = d_read & ~d_write;
            mem_write_d = d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_d = 1'b1;
`endif
          end else begin
            state_d     = ST_GNT_I;
            mem_read_d  = i_read & ~i_write;
            mem_write_d = i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_d = 1'b0;
`endif
          end
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        // Command is held until the memory completes; no preemption.
        if (mem_ready) begin
          state_d     = ST_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Read data is shared; only the ready pulse tells a cache the data is its own.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // mem_ready outside a grant state is ignored.
  assign i_ready = mem_ready & (state_q == ST_GNT_I);
  assign d_ready = mem_ready & (state_q == ST_GNT_D);

  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_ready && d_ready));
  a_one_cmd : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_ready, d_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model of the arbiter's memory of who was served last (1 = D).
  bit tb_last_d = 1'b0;

  typedef struct {
    bit                is_d;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(bit is_d, logic r, logic w,
                               logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
    exp_t e;
    e.is_d = is_d;
    e.wr = w;
    e.rd = r & ~w;
    e.addr = a;
    e.wdata = wd;
    sb.push_back(e);
  endfunction

  // Waits for the next grant, checks it against the oldest scoreboard entry,
  // holds it for lat cycles, then completes it with mem_ready.
  task automatic serve(input int lat, input logic [DATA_W-1:0] rd, input bit perturb,
                       output int grant_cyc, output int ready_cyc);
    int   n = 0;
    exp_t e;
    grant_cyc = -1;
    ready_cyc = -1;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!(mem_read || mem_write)) begin
      failures++;
      $display("FAIL grant_timeout: no command after %0d cycles", n);
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: command seen with no expected request");
      return;
    end
    grant_cyc = cyc;
    e = sb.pop_front();
    checks++;
    if (mem_read !== e.rd || mem_write !== e.wr || mem_addr !== e.addr) begin
      failures++;
      $display("FAIL grant_cmd: got rd=%0b wr=%0b addr=%h, want rd=%0b wr=%0b addr=%h",
               mem_read, mem_write, mem_addr, e.rd, e.wr, e.addr);
    end
    if (e.wr) begin
      checks++;
      if (mem_wdata !== e.wdata) begin
        failures++;
        $display("FAIL grant_wdata: got %h want %h", mem_wdata, e.wdata);
      end
    end
    for (int k = 0; k < lat; k++) begin
      if (perturb) begin
        i_addr  = ~i_addr;
        d_addr  = ~d_addr;
        i_wdata = ~i_wdata;
        d_wdata = ~d_wdata;
      end
      tick();
      checks++;
      if (mem_read !== e.rd || mem_write !== e.wr || mem_addr !== e.addr ||
          i_ready !== 1'b0 || d_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold: got rd=%0b wr=%0b addr=%h ir=%0b dr=%0b, want rd=%0b wr=%0b addr=%h no ready",
                 mem_read, mem_write, mem_addr, i_ready, d_ready, e.rd, e.wr, e.addr);
      end
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    ready_cyc = cyc;
    checks++;
    if (i_ready !== !e.is_d || d_ready !== e.is_d) begin
      failures++;
      $display("FAIL ready_route: got i_ready=%0b d_ready=%0b, want i_ready=%0b d_ready=%0b",
               i_ready, d_ready, !e.is_d, e.is_d);
    end
    checks++;
    if (i_rdata !== rd || d_rdata !== rd) begin
      failures++;
      $display("FAIL rdata: got i=%h d=%h want %h", i_rdata, d_rdata, rd);
    end
    tb_last_d = e.is_d;
    if (e.is_d) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
      i_write = 1'b0;
    end
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_quiet: got rd=%0b wr=%0b ir=%0b dr=%0b want all 0",
               mem_read, mem_write, i_ready, d_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tb_last_d = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_state: got rd=%0b wr=%0b addr=%h wdata=%h want zeros",
               mem_read, mem_write, mem_addr, mem_wdata);
    end
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready_ignored: got i=%0b d=%0b want 0 0", i_ready, d_ready);
    end
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    d_read = 1'b1;
    d_addr = 28'h0000030;
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_grant: mem_read got %0b want 1", mem_read);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_clear: mem_read got %0b want 0", mem_read);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (d_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_ready: d_ready got %0b want 0", d_ready);
    end
    tick();
    tick();
    mem_ready = 1'b0;
    d_read = 1'b0;
    rst_n = 1'b1;
    tb_last_d = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle_after: got rd=%0b wr=%0b want 0 0", mem_read, mem_write);
    end
  endtask

  task automatic test_i_read();
    int g, r;
    i_read = 1'b1;
    i_addr = 28'h0000010;
    push(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("FAIL arb_latency: mem_read got %0b want 0 before next edge", mem_read);
    end
    serve(2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, g, r);
  endtask

  task automatic test_d_write();
    int g, r;
    d_write = 1'b1;
    d_addr  = 28'h0000020;
    d_wdata = 128'hDEAD_BEEF_CAFE_BABE_0123_4567_89AB_F00D;
    push(1'b1, 1'b0, 1'b1, 28'h0000020, 128'hDEAD_BEEF_CAFE_BABE_0123_4567_89AB_F00D);
    serve(3, 128'h0, 1'b0, g, r);
    tick();
  endtask

  task automatic test_rw_both();
    int g, r;
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 28'h0ABCDEF;
    d_wdata = 128'h5A5A;
    push(1'b1, 1'b1, 1'b1, 28'h0ABCDEF, 128'h5A5A);
    serve(1, 128'h0, 1'b0, g, r);
    tick();
  endtask

  task automatic test_simultaneous();
    int  g1, r1, g2, r2;
    bit  first_d;
    `ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = !tb_last_d;
    `else
    first_d = 1'b1;
    `endif
    i_read = 1'b1;
    i_addr = 28'h0000100;
    d_read = 1'b1;
    d_addr = 28'h0000200;
    if (first_d) begin
      push(1'b1, 1'b1, 1'b0, 28'h0000200, '0);
      push(1'b0, 1'b1, 1'b0, 28'h0000100, '0);
    end else begin
      push(1'b0, 1'b1, 1'b0, 28'h0000100, '0);
      push(1'b1, 1'b1, 1'b0, 28'h0000200, '0);
    end
    serve(2, 128'hA1, 1'b0, g1, r1);
    serve(1, 128'hB2, 1'b0, g2, r2);
    checks++;
    if (g2 - r1 != 3) begin
      failures++;
      $display("FAIL back_to_back_gap: got %0d edges from ready to next grant, want 3", g2 - r1);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int g, r;
    d_read = 1'b1;
    d_addr = 28'h0000040;
    push(1'b1, 1'b1, 1'b0, 28'h0000040, '0);
    serve(1, 128'hC3, 1'b0, g, r);
    tick();
    test_simultaneous();
    test_simultaneous();
  endtask

  task automatic test_addr_hold();
    int g, r;
    i_read  = 1'b1;
    i_addr  = 28'h0000777;
    i_wdata = '0;
    push(1'b0, 1'b1, 1'b0, 28'h0000777, '0);
    serve(4, 128'hD4, 1'b1, g, r);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    test_reset();
    test_reset_mid_grant();
    test_i_read();
    test_d_write();
    test_rw_both();
    test_simultaneous();
    test_round_robin();
    test_addr_hold();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d expected grants never seen, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
